// File: rtl/reg_file_access_sequencer_if.sv
// Bus bundle between the register-file sequencer, the core pipeline and the
// simple dual-port BRAM that holds the architectural registers.
interface reg_file_access_sequencer_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  read_enable;
  logic                  read_ready;
  logic [ADDR_WIDTH-1:0] read_rs1_addr;
  logic [ADDR_WIDTH-1:0] read_rs2_addr;
  logic                  read_en_out;
  logic [DATA_WIDTH-1:0] read_rs1_data_out;
  logic [DATA_WIDTH-1:0] read_rs2_data_out;

  logic                  wb0_req;
  logic [ADDR_WIDTH-1:0] wb0_addr;
  logic [DATA_WIDTH-1:0] wb0_data;
  logic                  wb0_ack;
  logic                  wb1_req;
  logic [ADDR_WIDTH-1:0] wb1_addr;
  logic [DATA_WIDTH-1:0] wb1_data;
  logic                  wb1_ack;

  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic                  ram_write_en;

  modport slave (
    input  read_enable, read_rs1_addr, read_rs2_addr,
    input  wb0_req, wb0_addr, wb0_data, wb1_req, wb1_addr, wb1_data,
    input  ram_dout,
    output read_ready, read_en_out, read_rs1_data_out, read_rs2_data_out,
    output wb0_ack, wb1_ack,
    output ram_raddr, ram_waddr, ram_din, ram_write_en
  );

  modport master (
    output read_enable, read_rs1_addr, read_rs2_addr,
    output wb0_req, wb0_addr, wb0_data, wb1_req, wb1_addr, wb1_data,
    output ram_dout,
    input  read_ready, read_en_out, read_rs1_data_out, read_rs2_data_out,
    input  wb0_ack, wb1_ack,
    input  ram_raddr, ram_waddr, ram_din, ram_write_en
  );
endinterface

// File: rtl/reg_file_access_sequencer.sv
// Serialises rs1/rs2 reads through one BRAM read port and arbitrates two
// writeback requesters onto one write port, with x0, bypass and anti-starvation.
module reg_file_access_sequencer #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 3
) (
  input logic                        clk,
  input logic                        reset_n,
  reg_file_access_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, RD1, RD2} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rs1_q;
  logic [ADDR_WIDTH-1:0] rs2_q;
  logic                  bypass_valid;
  logic [DATA_WIDTH-1:0] bypass_data;
  logic [DATA_WIDTH-1:0] rs1_val;
  logic [CNT_W-1:0]      starve_cnt;

  logic                  accept;
  logic                  starved;
  logic                  grant0;
  logic                  grant1;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  write_en;

  assign bus.read_ready = reset_n && (state == IDLE || state == RD2);
  assign accept         = bus.read_enable && bus.read_ready;
  assign bus.ram_raddr  = (state == RD1) ? rs2_q : bus.read_rs1_addr;

  // wb1 overrides wb0 once it has been turned away STARVE_LIMIT cycles in a row
  assign starved  = bus.wb1_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant1   = reset_n && bus.wb1_req && (!bus.wb0_req || starved);
  assign grant0   = reset_n && bus.wb0_req && !grant1;
  assign waddr    = grant1 ? bus.wb1_addr : bus.wb0_addr;
  assign wdata    = grant1 ? bus.wb1_data : bus.wb0_data;
  assign write_en = (grant0 || grant1) && (waddr != '0);

  assign bus.wb0_ack      = grant0;
  assign bus.wb1_ack      = grant1;
  assign bus.ram_waddr    = waddr;
  assign bus.ram_din      = wdata;
  assign bus.ram_write_en = write_en;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state                 <= IDLE;
      rs1_q                 <= '0;
      rs2_q                 <= '0;
      bypass_valid          <= 1'b0;
      bypass_data           <= '0;
      rs1_val               <= '0;
      starve_cnt            <= '0;
      bus.read_en_out       <= 1'b0;
      bus.read_rs1_data_out <= '0;
      bus.read_rs2_data_out <= '0;
    end else begin
      bus.read_en_out <= 1'b0;
      case (state)
        IDLE: state <= IDLE;
        RD1: begin
          // the rs1 RAM read was issued alongside any accept-cycle write, so it returns stale data
          if (rs1_q == '0)       rs1_val <= '0;
          else if (bypass_valid) rs1_val <= bypass_data;
          else                   rs1_val <= bus.ram_dout;
          state <= RD2;
        end
        RD2: begin
          bus.read_rs1_data_out <= rs1_val;
          bus.read_rs2_data_out <= (rs2_q == '0) ? '0 : bus.ram_dout;
          bus.read_en_out       <= 1'b1;
          state                 <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        state        <= RD1;
        rs1_q        <= bus.read_rs1_addr;
        rs2_q        <= bus.read_rs2_addr;
        bypass_valid <= write_en && (waddr == bus.read_rs1_addr);
        bypass_data  <= wdata;
      end

      if (!bus.wb1_req || grant1)
        starve_cnt <= '0;
      else if (starve_cnt != CNT_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_reg_file_access_sequencer.sv
// Bench for reg_file_access_sequencer: behavioural BRAM, a register-array
// reference model, directed scenarios followed by a constrained-random phase.
module tb_reg_file_access_sequencer;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SL = 3;

  typedef struct {
    int            due;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
  } rd_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  reg_file_access_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  reg_file_access_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // BRAM: registered read, read-during-write returns the old word
  logic [DW-1:0] mem [32];
  logic [DW-1:0] init_vals [32];
  logic          load_mem;
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_vals[i];
    end else if (bus.ram_write_en) begin
      mem[bus.ram_waddr] <= bus.ram_din;
    end
    bus.ram_dout <= mem[bus.ram_raddr];
  end

  logic [DW-1:0] ref_regs [32];
  rd_t           pend_q [$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            last_acc = -100;
  int            starve = 0;
  logic [AW-1:0] pend_rs2 = '0;
  logic [DW-1:0] held1 = '0;
  logic [DW-1:0] held2 = '0;
  logic          prev_rst_n = 1'b0;
  logic          g0_prev = 1'b0;
  logic          g1_prev = 1'b0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock of comparisons and reference-model update; inputs are already driven
  task automatic tick();
    logic          ready_e, acc_e, g0_e, g1_e, we_e, pulse_e;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    rd_t           e;
    @(negedge clk);
    ready_e = reset_n && (last_acc != cyc - 1);
    acc_e   = bus.read_enable && ready_e;
    g1_e    = reset_n && bus.wb1_req && (!bus.wb0_req || starve == SL);
    g0_e    = reset_n && bus.wb0_req && !g1_e;
    wa      = g1_e ? bus.wb1_addr : bus.wb0_addr;
    wd      = g1_e ? bus.wb1_data : bus.wb0_data;
    we_e    = (g0_e || g1_e) && (wa != '0);

    checkOutput("read_ready", DW'(bus.read_ready), DW'(ready_e));
    checkOutput("wb0_ack", DW'(bus.wb0_ack), DW'(g0_e));
    checkOutput("wb1_ack", DW'(bus.wb1_ack), DW'(g1_e));
    checkOutput("ram_write_en", DW'(bus.ram_write_en), DW'(we_e));
    if (we_e) begin
      checkOutput("ram_waddr", DW'(bus.ram_waddr), DW'(wa));
      checkOutput("ram_din", bus.ram_din, wd);
    end
    if (acc_e)
      checkOutput("ram_raddr_rs1", DW'(bus.ram_raddr), DW'(bus.read_rs1_addr));
    else if (reset_n && last_acc == cyc - 1)
      checkOutput("ram_raddr_rs2", DW'(bus.ram_raddr), DW'(pend_rs2));

    pulse_e = (pend_q.size() > 0) && (pend_q[0].due == cyc);
    checkOutput("read_en_out", DW'(bus.read_en_out), DW'(pulse_e));
    if (pulse_e) begin
      e     = pend_q.pop_front();
      held1 = e.r1;
      held2 = e.r2;
    end
    if (!(!reset_n && prev_rst_n)) begin
      checkOutput("rs1_data", bus.read_rs1_data_out, held1);
      checkOutput("rs2_data", bus.read_rs2_data_out, held2);
    end

    if (we_e) ref_regs[wa] = wd;
    if (acc_e) begin
      e.due = cyc + 3;
      e.r1  = (bus.read_rs1_addr == '0) ? '0 : ref_regs[bus.read_rs1_addr];
      e.r2  = (bus.read_rs2_addr == '0) ? '0 : ref_regs[bus.read_rs2_addr];
      pend_q.push_back(e);
      last_acc = cyc;
      pend_rs2 = bus.read_rs2_addr;
    end
    if (!reset_n) begin
      pend_q.delete();
      last_acc = -100;
      held1    = '0;
      held2    = '0;
      starve   = 0;
    end else if (bus.wb1_req && !g1_e) begin
      starve = (starve < SL) ? starve + 1 : SL;
    end else begin
      starve = 0;
    end
    g0_prev    = g0_e;
    g1_prev    = g1_e;
    prev_rst_n = reset_n;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(
    input logic re, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
    input logic w0r, input logic [AW-1:0] w0a, input logic [DW-1:0] w0d,
    input logic w1r, input logic [AW-1:0] w1a, input logic [DW-1:0] w1d
  );
    bus.read_enable   = re;
    bus.read_rs1_addr = a1;
    bus.read_rs2_addr = a2;
    bus.wb0_req       = w0r;
    bus.wb0_addr      = w0a;
    bus.wb0_data      = w0d;
    bus.wb1_req       = w1r;
    bus.wb1_addr      = w1a;
    bus.wb1_data      = w1d;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic          re, w0r, w1r;
    logic [AW-1:0] a1, a2, w0a, w1a;
    logic [DW-1:0] w0d, w1d;

    reset_n  = 1'b0;
    load_mem = 1'b1;
    for (int i = 0; i < 32; i++) begin
      init_vals[i] = $urandom;
      ref_regs[i]  = init_vals[i];
    end
    bus.read_enable = 0; bus.read_rs1_addr = 0; bus.read_rs2_addr = 0;
    bus.wb0_req = 0; bus.wb0_addr = 0; bus.wb0_data = 0;
    bus.wb1_req = 0; bus.wb1_addr = 0; bus.wb1_data = 0;
    repeat (2) @(posedge clk);
    #1;
    load_mem = 1'b0;

    idle(1);
    reset_n = 1'b1;
    idle(1);

    // x5 write then read rs1=5, rs2=0
    applyStimulus(0, 0, 0, 1, 5, 32'h1234_5678, 0, 0, 0);
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0);
    idle(4);

    // same-cycle write to x7 is bypassed, the T+1 write is excluded
    applyStimulus(1, 7, 7, 1, 7, 32'hAAAA_0001, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 7, 32'h0000_BBBB, 0, 0, 0);
    idle(3);
    applyStimulus(1, 7, 7, 0, 0, 0, 0, 0, 0);
    idle(4);

    // back-to-back accepts with an ignored request in the RD1 cycle
    applyStimulus(0, 0, 0, 1, 1, 32'h1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 2, 32'h2, 0, 0, 0);
    applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 2, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 2, 1, 0, 0, 0, 0, 0, 0);
    idle(4);

    // wb0 hogs the port; wb1 forces through on its fourth cycle
    applyStimulus(0, 0, 0, 1, 11, 32'h11, 1, 9, 32'h55);
    applyStimulus(0, 0, 0, 1, 12, 32'h12, 1, 9, 32'h55);
    applyStimulus(0, 0, 0, 1, 13, 32'h13, 1, 9, 32'h55);
    applyStimulus(0, 0, 0, 1, 14, 32'h14, 1, 9, 32'h55);
    applyStimulus(0, 0, 0, 1, 14, 32'h14, 0, 0, 0);
    applyStimulus(1, 9, 14, 0, 0, 0, 0, 0, 0);
    idle(4);

    // x0 write is acked but never reaches the RAM
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);

    // reset while the read sits in RD1 abandons it
    applyStimulus(1, 5, 7, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    applyStimulus(0, 0, 0, 1, 3, 32'h33, 1, 4, 32'h44);
    applyStimulus(0, 0, 0, 1, 3, 32'h33, 1, 4, 32'h44);
    reset_n = 1'b1;
    idle(5);

    // random traffic; requesters hold until the model says they were acked
    w0r = 0; w0a = 0; w0d = 0; w1r = 0; w1a = 0; w1d = 0;
    for (int i = 0; i < 400; i++) begin
      re = ($urandom_range(0, 9) < 7);
      a1 = AW'($urandom_range(0, 7));
      a2 = AW'($urandom_range(0, 7));
      if (!(w0r && !g0_prev)) begin
        w0r = ($urandom_range(0, 2) != 0);
        w0a = AW'($urandom_range(0, 7));
        w0d = $urandom;
      end
      if (!(w1r && !g1_prev)) begin
        w1r = ($urandom_range(0, 1) != 0);
        w1a = AW'($urandom_range(0, 7));
        w1d = $urandom;
      end
      reset_n = ($urandom_range(0, 79) != 0);
      applyStimulus(re, a1, a2, w0r, w0a, w0d, w1r, w1a, w1d);
    end
    reset_n = 1'b1;
    idle(6);
    checkOutput("reads_drained", DW'(pend_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
